// File: rtl/port_arb_pkg.sv
// Shared definitions for the port access arbiter: command encodings, grant index
// decoding and the tag-width sanity check.
package port_arb_pkg;

    localparam logic CMD_READ  = 1'b0;
    localparam logic CMD_WRITE = 1'b1;

    // Grant indices are carried at the widest supported requester count (8).
    localparam int unsigned IDX_W = 3;

    function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [7:0] oh);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < 8; i++) begin
            if (oh[i]) idx = IDX_W'(i);
        end
        return idx;
    endfunction

    function automatic bit id_width_ok(input int unsigned id_w, input int unsigned n);
        return (n >= 2) && (n <= 8) && ((1 << id_w) >= n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant: first valid requester searching upward from ptr, wrapping at N.
module rr_arbiter
    import port_arb_pkg::*;
#(
    parameter int N = 2
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    input  logic             adv,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic [IDX_W-1:0] ptr_nxt
);

    logic found;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            int j;
            j = int'(ptr) + i;
            if (j >= N) j = j - N;
            if (!found && req[j]) begin
                gnt[j] = 1'b1;
                found  = 1'b1;
            end
        end
    end

    assign gnt_idx = onehot_to_idx(8'(gnt));

    // Kept separate from the grant logic so adv (derived from gnt) forms no loop.
    always_comb begin
        ptr_nxt = ptr;
        if (adv) begin
            ptr_nxt = (gnt_idx == IDX_W'(N - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

endmodule

// File: rtl/port_access_arbiter.sv
// Shares one single-port slave between NUM_REQ requesters with round-robin grant and
// in-order tagged responses. Optional address range check: define ARB_ADDR_CHECK_EN.
module port_access_arbiter
    import port_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int NUM_REQ    = 2,
    parameter int ID_WIDTH   = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ-1:0]            req_we,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_d,
    output logic                          rsp_valid,
    output logic [ID_WIDTH-1:0]           rsp_id,
    output logic                          rsp_we,
    output logic                          rsp_err,
    output logic [DATA_WIDTH-1:0]         rsp_data,
    output logic [ADDR_WIDTH-1:0]         ram_addr,
    output logic [DATA_WIDTH-1:0]         ram_d,
    output logic                          ram_req,
    output logic                          ram_we,
    input  logic [DATA_WIDTH-1:0]         ram_q,
    input  logic [ADDR_WIDTH-1:0]         ram_len
);

    if (!id_width_ok(ID_WIDTH, NUM_REQ)) begin : g_bad_cfg
        $error("port_access_arbiter: NUM_REQ out of range or ID_WIDTH too small");
    end

    // Reset asserts asynchronously, releases two clocks after rst rises.
    logic rst_meta_q, rst_sync_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rst_meta_q <= 1'b0;
            rst_sync_q <= 1'b0;
        end else begin
            rst_meta_q <= 1'b1;
            rst_sync_q <= rst_meta_q;
        end
    end

    logic [NUM_REQ-1:0]    req_act, gnt;
    logic [IDX_W-1:0]      gnt_idx, ptr_q, ptr_d;
    logic                  xfer, addr_err;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_d;
    logic                  sel_we;

    assign req_act   = req_valid & {NUM_REQ{rst_sync_q}};
    assign req_ready = gnt;
    assign xfer      = |gnt;

    rr_arbiter #(.N(NUM_REQ)) u_rr (
        .req    (req_act),
        .ptr    (ptr_q),
        .adv    (xfer),
        .gnt    (gnt),
        .gnt_idx(gnt_idx),
        .ptr_nxt(ptr_d)
    );

    always_comb begin
        sel_addr = '0;
        sel_d    = '0;
        sel_we   = CMD_READ;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                sel_addr = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_d    = req_d[i*DATA_WIDTH +: DATA_WIDTH];
                sel_we   = req_we[i];
            end
        end
    end

`ifdef ARB_ADDR_CHECK_EN
    assign addr_err = (sel_addr >= ram_len);
`else
    logic unused_ram_len;
    assign unused_ram_len = ^ram_len;
    assign addr_err       = 1'b0;
`endif

    logic                  ram_req_q, ram_we_q;
    logic [ADDR_WIDTH-1:0] ram_addr_q;
    logic [DATA_WIDTH-1:0] ram_d_q;
    logic                  s1_vld_q, s1_we_q, s1_err_q;
    logic [ID_WIDTH-1:0]   s1_id_q;
    logic                  rsp_valid_q, rsp_we_q, rsp_err_q;
    logic [ID_WIDTH-1:0]   rsp_id_q;

    always_ff @(posedge clk or negedge rst_sync_q) begin
        if (!rst_sync_q) begin
            ptr_q       <= '0;
            ram_req_q   <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_d_q     <= '0;
            s1_vld_q    <= 1'b0;
            s1_we_q     <= 1'b0;
            s1_err_q    <= 1'b0;
            s1_id_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_we_q    <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_id_q    <= '0;
        end else begin
            ptr_q     <= ptr_d;
            // Stage 1: slave command; rejected commands keep only their tag.
            s1_vld_q  <= xfer;
            s1_err_q  <= xfer & addr_err;
            ram_req_q <= xfer & ~addr_err;
            if (xfer) begin
                s1_id_q <= ID_WIDTH'(gnt_idx);
                s1_we_q <= sel_we;
            end
            if (xfer && !addr_err) begin
                ram_addr_q <= sel_addr;
                ram_d_q    <= sel_d;
                ram_we_q   <= (sel_we == CMD_WRITE);
            end
            // Stage 2: response tag, aligned with the slave's read data.
            rsp_valid_q <= s1_vld_q;
            rsp_id_q    <= s1_id_q;
            rsp_we_q    <= s1_we_q;
            rsp_err_q   <= s1_err_q;
        end
    end

    assign ram_req   = ram_req_q;
    assign ram_we    = ram_we_q;
    assign ram_addr  = ram_addr_q;
    assign ram_d     = ram_d_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_we    = rsp_we_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_data  = rsp_err_q ? '0 : ram_q;

endmodule

// File: tb/tb_port_access_arbiter.sv
// Directed bench for port_access_arbiter with a behavioural slave and a response scoreboard.
module tb_port_access_arbiter;

    typedef struct packed {
        logic [2:0] id;
        logic       we;
        logic       err;
        logic [7:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid, req_ready, req_we;
    logic [7:0]  req_addr;
    logic [15:0] req_d;
    logic        rsp_valid, rsp_we, rsp_err;
    logic [2:0]  rsp_id;
    logic [7:0]  rsp_data;
    logic [3:0]  ram_addr, ram_len;
    logic [7:0]  ram_d, ram_q;
    logic        ram_req, ram_we;

    int checks = 0;
    int errors = 0;

    exp_t       sb [$];
    exp_t       cur;
    logic [7:0] model [16];
    logic [7:0] mem   [16];
    logic       preload;
    logic [1:0] mptr;

    always #5 clk = ~clk;

    port_access_arbiter #(
        .DATA_WIDTH(8), .ADDR_WIDTH(4), .NUM_REQ(2), .ID_WIDTH(3)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_d(req_d),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_we(rsp_we),
        .rsp_err(rsp_err), .rsp_data(rsp_data),
        .ram_addr(ram_addr), .ram_d(ram_d), .ram_req(ram_req), .ram_we(ram_we),
        .ram_q(ram_q), .ram_len(ram_len)
    );

    function automatic logic [7:0] init_val(input int a);
        return (a == 3) ? 8'h5A : 8'hA0 + 8'(a);
    endfunction

    // Slave: registered read-before-write, output holds when not requested.
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 16; i++) mem[i] <= init_val(i);
            ram_q <= 8'h00;
        end else if (ram_req) begin
            ram_q <= mem[ram_addr];
            if (ram_we) mem[ram_addr] <= ram_d;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rsp_valid) begin
            chk("rsp_pending", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
                cur = sb.pop_front();
                chk("rsp_id",   32'(rsp_id),   32'(cur.id));
                chk("rsp_we",   32'(rsp_we),   32'(cur.we));
                chk("rsp_err",  32'(rsp_err),  32'(cur.err));
                chk("rsp_data", 32'(rsp_data), 32'(cur.data));
            end
        end
    end

    // One cycle: drive at the falling edge, observe the grant, queue expected responses.
    task automatic step(input logic [1:0] v, input logic [1:0] we, input logic [7:0] addr,
                        input logic [15:0] d, input logic chk_gnt,
                        output logic [1:0] rdy, output logic rv);
        exp_t       e;
        logic [3:0] a;
        logic [1:0] exp_rdy;
        logic       bad;
        @(negedge clk);
        rv        = rsp_valid;
        req_valid = v;
        req_we    = we;
        req_addr  = addr;
        req_d     = d;
        #1;
        rdy = req_ready;
        exp_rdy = 2'b00;
        if (v[mptr]) exp_rdy[mptr] = 1'b1;
        else if (v[~mptr[0]]) exp_rdy[~mptr[0]] = 1'b1;
        if (chk_gnt) chk("grant", 32'(rdy), 32'(exp_rdy));
        for (int i = 0; i < 2; i++) begin
            if (v[i] && rdy[i]) begin
                a    = addr[i*4 +: 4];
                e.id = 3'(i);
                e.we = we[i];
                bad  = 1'b0;
`ifdef ARB_ADDR_CHECK_EN
                bad  = (a >= ram_len);
`endif
                if (bad) begin
                    e.err  = 1'b1;
                    e.data = 8'h00;
                end else begin
                    e.err  = 1'b0;
                    e.data = model[a];
                    if (we[i]) model[a] = d[i*8 +: 8];
                end
                sb.push_back(e);
                mptr = (i == 1) ? 2'd0 : 2'd1;
            end
        end
    endtask

    task automatic idle(output logic rv);
        logic [1:0] r;
        step(2'b00, 2'b00, 8'h00, 16'h0000, 1'b0, r, rv);
    endtask

    initial begin
        logic [1:0] rdy;
        logic       rv;
        logic       got;
        logic [1:0] seq [4];
        logic       rvs [6];

        for (int i = 0; i < 16; i++) model[i] = init_val(i);
        mptr      = 2'd0;
        preload   = 1'b1;
        rst       = 1'b0;
        ram_len   = 4'd10;
        req_valid = 2'b11;
        req_we    = 2'b00;
        req_addr  = 8'h00;
        req_d     = 16'h0000;

        // Reset holds off every grant even with all requesters valid.
        repeat (2) @(negedge clk);
        preload = 1'b0;
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_ram_req",   32'(ram_req),   32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_id",    32'(rsp_id),    32'd0);
        chk("rst_ram_addr",  32'(ram_addr),  32'd0);

        rst = 1'b1;
        req_valid = 2'b00;
        got = 1'b0;
        rdy = 2'b00;
        for (int k = 0; k < 6 && !got; k++) begin
            step(2'b01, 2'b00, 8'h00, 16'h0000, 1'b0, rdy, rv);
            if (rdy != 2'b00) got = 1'b1;
        end
        chk("release_grant_seen", 32'(got), 32'd1);
        chk("release_grant",      32'(rdy), 32'h1);

        // Single read by requester 1.
        step(2'b10, 2'b00, 8'h30, 16'h0000, 1'b1, rdy, rv);
        idle(rv);
        chk("rd_ram_req",  32'(ram_req),  32'd1);
        chk("rd_ram_addr", 32'(ram_addr), 32'd3);
        chk("rd_ram_we",   32'(ram_we),   32'd0);
        idle(rv);
        chk("rd_rsp_valid", 32'(rv), 32'd1);
        idle(rv);

        // Contention: strict alternation, responses with no gaps.
        for (int k = 0; k < 6; k++) begin
            if (k < 4) step(2'b11, 2'b00, 8'h21 + 8'(k), 16'h0000, 1'b1, seq[k], rvs[k]);
            else       idle(rvs[k]);
        end
        chk("cont_g0", 32'(seq[0]), 32'h1);
        chk("cont_g1", 32'(seq[1]), 32'h2);
        chk("cont_g2", 32'(seq[2]), 32'h1);
        chk("cont_g3", 32'(seq[3]), 32'h2);
        for (int k = 2; k < 6; k++) chk("cont_rsp_valid", 32'(rvs[k]), 32'd1);
        repeat (2) idle(rv);

        // Back-to-back writes by requester 0.
        for (int k = 0; k < 10; k++) begin
            step(2'b01, 2'b01, {4'h0, 4'(k)}, {8'h00, 8'h10 + 8'(k)}, 1'b1, rdy, rv);
            chk("wr_grant", 32'(rdy), 32'h1);
        end
        repeat (3) idle(rv);
        for (int k = 0; k < 10; k++) chk("wr_mem", 32'(mem[k]), 32'h10 + k);

        // Reset while two reads are in flight: nothing is answered.
        step(2'b01, 2'b00, 8'h01, 16'h0000, 1'b1, rdy, rv);
        step(2'b01, 2'b00, 8'h02, 16'h0000, 1'b1, rdy, rv);
        @(posedge clk);
        #1;
        rst = 1'b0;
        req_valid = 2'b11;
        sb.delete();
        mptr = 2'd0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
            chk("mid_rst_ram_req",   32'(ram_req),   32'd0);
            chk("mid_rst_ready",     32'(req_ready), 32'd0);
        end
        rst = 1'b1;
        req_valid = 2'b00;
        repeat (3) idle(rv);

        // Out-of-range address.
        step(2'b01, 2'b00, 8'h0C, 16'h0000, 1'b1, rdy, rv);
        idle(rv);
`ifdef ARB_ADDR_CHECK_EN
        chk("oor_ram_req", 32'(ram_req), 32'd0);
`else
        chk("oor_ram_req", 32'(ram_req), 32'd1);
`endif
        repeat (2) idle(rv);

        // Mixed random traffic.
        for (int k = 0; k < 24; k++) begin
            step(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 8'($urandom),
                 16'($urandom), 1'b1, rdy, rv);
        end
        repeat (4) idle(rv);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
